// File: rtl/instr_loader_if.sv
// Byte-stream input and instruction-RAM write port of the program loader.
interface instr_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr_addr;
  logic [15:0] instr_wdata;
  logic        instr_wen;

  modport slave  (input in_data, in_valid, output in_ready, instr_addr, instr_wdata, instr_wen);
  modport master (output in_data, in_valid, input in_ready, instr_addr, instr_wdata, instr_wen);
endinterface

// File: rtl/instr_loader.sv
// Loads a length-prefixed, big-endian byte frame into instruction RAM while holding the CPU.
// Define INSTR_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte before release.
module instr_loader #(
  parameter logic [15:0] START_ADDR = 16'h0000,
  parameter logic [15:0] MAX_WORDS  = 16'hFFFF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  instr_loader_if.slave bus,
  output logic          cpu_hold,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [15:0]   words_loaded
);
  localparam int STAGES = 1;

  typedef enum logic [2:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO,
`ifdef INSTR_LOADER_CHECKSUM_EN
    CHK,
`endif
    DONE, ERR
  } state_t;

  // Where the frame goes once the last word (or an empty length) has been taken.
`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam state_t TAIL = CHK;
`else
  localparam state_t TAIL = DONE;
`endif

  state_t state, nxt;
  logic [15:0] len;
  logic [7:0]  hi;
  logic        acc;
  logic        idle_like;
  logic [15:0] len_in;
  logic [15:0] cnt_inc;
  logic [STAGES:0] vld_pipe;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign acc       = bus.in_valid & bus.in_ready;
  assign idle_like = (state == IDLE) || (state == DONE) || (state == ERR);
  assign len_in    = {len[15:8], bus.in_data};
  assign cnt_inc   = words_loaded + 16'd1;

  // Write strobe lags the accepting edge by STAGES cycles.
  assign vld_pipe[0]   = acc && (state == DATA_LO);
  assign bus.instr_wen = vld_pipe[STAGES];

  assign busy     = !idle_like;
  assign done     = (state == DONE);
  assign error    = (state == ERR);
  assign cpu_hold = (state != DONE);

  always_comb begin
    bus.in_ready = 1'b0;
    case (state)
      LEN_HI, LEN_LO, DATA_HI, DATA_LO: bus.in_ready = 1'b1;
`ifdef INSTR_LOADER_CHECKSUM_EN
      CHK:                              bus.in_ready = 1'b1;
`endif
      default:                          bus.in_ready = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE, DONE, ERR: if (start) nxt = LEN_HI;
      LEN_HI:          if (acc) nxt = LEN_LO;
      LEN_LO: if (acc) begin
        if (len_in > MAX_WORDS) nxt = ERR;
        else if (len_in == 16'd0) nxt = TAIL;
        else nxt = DATA_HI;
      end
      DATA_HI:         if (acc) nxt = DATA_LO;
      DATA_LO:         if (acc) nxt = (cnt_inc == len) ? TAIL : DATA_HI;
`ifdef INSTR_LOADER_CHECKSUM_EN
      CHK:             if (acc) nxt = (bus.in_data == csum) ? DONE : ERR;
`endif
      default:         nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      len                <= '0;
      hi                 <= '0;
      words_loaded       <= '0;
      bus.instr_addr     <= START_ADDR;
      bus.instr_wdata    <= '0;
      vld_pipe[STAGES:1] <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum               <= '0;
`endif
    end else begin
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      if (start && idle_like) begin
        words_loaded <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum         <= '0;
`endif
      end
      if (acc) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
        csum <= csum ^ bus.in_data;
`endif
        case (state)
          LEN_HI:  len[15:8] <= bus.in_data;
          LEN_LO:  len[7:0]  <= bus.in_data;
          DATA_HI: hi        <= bus.in_data;
          DATA_LO: begin
            bus.instr_wdata <= {hi, bus.in_data};
            bus.instr_addr  <= START_ADDR + words_loaded;
            words_loaded    <= cnt_inc;
          end
          default: ;
        endcase
      end
    end
  end
endmodule
